// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared FSM state type and stats counter width
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int STATS_CNT_W = 16;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester handshake and FIFO write port bundle
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          full;
  logic                          wr;
  logic [DATA_WIDTH-1:0]         w_data;

  modport master (
    output req_valid, req_data, full,
    input  req_ready, wr, w_data
  );

  modport slave (
    input  req_valid, req_data, full,
    output req_ready, wr, w_data
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin first-one finder
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IW-1:0]      rr_ptr,
  output logic [IW-1:0]      idx,
  output logic               found
);

  // Scan from the farthest offset down so the nearest valid bit wins last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int i;
      i = (int'(rr_ptr) + k) % NUM_REQ;
      if (valid[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter onto one FIFO write port
// Optional per-requester accepted-word counters via FIFO_WR_ARBITER_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int IW        = $clog2(NUM_REQ),
  localparam int BW        = $clog2(MAX_BURST) + 1
) (
  input  logic                clk,
  input  logic                reset_n,
  fifo_wr_arbiter_if.slave    bus,
  output logic [IW-1:0]       grant_id,
  output logic                busy
`ifdef FIFO_WR_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*STATS_CNT_W-1:0] acc_cnt
`endif
);

  arb_state_t    state, state_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [IW-1:0] rr_ptr, rr_nxt;
  logic [BW-1:0] burst_cnt, burst_nxt;
  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic          accept;
  logic [IW-1:0] owner_succ;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr_pick (
    .valid  (bus.req_valid),
    .rr_ptr (rr_ptr),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      rr_ptr    <= rr_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  assign owner_succ = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    rr_nxt        = rr_ptr;
    burst_nxt     = burst_cnt;
    busy          = (state == GRANT);
    accept        = busy && bus.req_valid[owner] && !bus.full;
    bus.wr        = accept;
    bus.req_ready = '0;
    bus.w_data    = '0;
    grant_id      = '0;

    if (busy) begin
      grant_id   = owner;
      bus.w_data = bus.req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
      for (int i = 0; i < NUM_REQ; i++) begin
        bus.req_ready[i] = (IW'(i) == owner) && !bus.full;
      end
    end

    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = GRANT;
          owner_nxt = pick_idx;
          burst_nxt = '0;
        end
      end
      GRANT: begin
        // A dropped valid releases even while full holds the port.
        if (!bus.req_valid[owner] || (accept && burst_cnt == BW'(MAX_BURST - 1))) begin
          state_nxt = IDLE;
          rr_nxt    = owner_succ;
          burst_nxt = '0;
        end else if (accept) begin
          burst_nxt = burst_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [STATS_CNT_W-1:0] cnt [NUM_REQ];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else if (accept && cnt[owner] != '1) begin
      cnt[owner] <= cnt[owner] + 1'b1;
    end
  end

  always_comb begin
    acc_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      acc_cnt[i*STATS_CNT_W +: STATS_CNT_W] = cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] grant_id;
  logic       busy;
`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [NUM_REQ*16-1:0] acc_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_data  [4];
  logic [3:0] exp_ready [4];

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    .acc_cnt  (acc_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_idle(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_wr"}, 32'(bus.wr), 0);
    check_eq({tag, "_gid"}, 32'(grant_id), 0);
    check_eq({tag, "_rdy"}, 32'(bus.req_ready), 0);
  endtask

  task automatic chk_write(input string tag, input int g);
    check_eq({tag, "_busy"}, 32'(busy), 1);
    check_eq({tag, "_wr"}, 32'(bus.wr), 1);
    check_eq({tag, "_gid"}, 32'(grant_id), 32'(g));
    check_eq({tag, "_wdata"}, 32'(bus.w_data), 32'(exp_data[g]));
    check_eq({tag, "_rdy"}, 32'(bus.req_ready), 32'(exp_ready[g]));
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    bus.req_valid = '0;
    bus.full      = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic push_words(input int idx, input int n);
    int got;
    got = 0;
    bus.req_valid = 4'(1 << idx);
    for (int c = 0; c < 60 && got < n; c++) begin
      #1;
      if (bus.wr) got++;
      @(negedge clk);
    end
    check_eq("push_count", 32'(got), 32'(n));
    bus.req_valid = '0;
    #1;
    check_eq("push_drop_wr", 32'(bus.wr), 0);
    @(negedge clk);
  endtask

  initial begin
    exp_data  = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    exp_ready = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    reset_n       = 1'b0;
    bus.req_valid = '0;
    bus.full      = 1'b0;
    bus.req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    @(negedge clk);
    #1;
    chk_idle("rst");
    check_eq("rst_wdata", 32'(bus.w_data), 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int c = 0; c < 10; c++) begin
      #1;
      chk_idle("novalid");
      @(negedge clk);
    end

    // All four requesting: 0,1,2,3,0 each bubble + MAX_BURST writes
    do_reset();
    bus.req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      #1;
      chk_idle("rr_bubble");
      @(negedge clk);
      for (int b = 0; b < MAX_BURST; b++) begin
        #1;
        chk_write("rr_write", g % 4);
        @(negedge clk);
      end
    end

    // Owner 2 stalled by full after two words
    do_reset();
    bus.req_valid = 4'b0100;
    #1; chk_idle("full_bubble"); @(negedge clk);
    for (int b = 0; b < 2; b++) begin #1; chk_write("full_pre", 2); @(negedge clk); end
    bus.full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check_eq("full_wr", 32'(bus.wr), 0);
      check_eq("full_rdy", 32'(bus.req_ready), 0);
      check_eq("full_gid", 32'(grant_id), 2);
      check_eq("full_busy", 32'(busy), 1);
      @(negedge clk);
    end
    bus.full = 1'b0;
    for (int b = 0; b < 2; b++) begin #1; chk_write("full_post", 2); @(negedge clk); end
    #1; chk_idle("full_release"); @(negedge clk);

    // Requester 1 drops after 2 words; requester 2 is next
    do_reset();
    bus.req_valid = 4'b0110;
    #1; chk_idle("drop_bubble"); @(negedge clk);
    for (int b = 0; b < 2; b++) begin #1; chk_write("drop_w", 1); @(negedge clk); end
    bus.req_valid = 4'b0100;
    #1;
    check_eq("drop_wr", 32'(bus.wr), 0);
    check_eq("drop_gid", 32'(grant_id), 1);
    @(negedge clk);
    #1; chk_idle("drop_bubble2"); @(negedge clk);
    #1; chk_write("drop_next", 2); @(negedge clk);

    // Requester 1 drops with only requester 0 left: wraps to 0
    do_reset();
    bus.req_valid = 4'b0010;
    #1; chk_idle("wrap_bubble"); @(negedge clk);
    for (int b = 0; b < 2; b++) begin #1; chk_write("wrap_w", 1); @(negedge clk); end
    bus.req_valid = 4'b0001;
    #1; check_eq("wrap_drop_wr", 32'(bus.wr), 0); @(negedge clk);
    #1; chk_idle("wrap_bubble2"); @(negedge clk);
    #1; chk_write("wrap_next", 0); @(negedge clk);

    // Asynchronous reset mid-burst of requester 3
    do_reset();
    bus.req_valid = 4'b1000;
    #1; chk_idle("mid_bubble"); @(negedge clk);
    for (int b = 0; b < 2; b++) begin #1; chk_write("mid_w", 3); @(negedge clk); end
    reset_n = 1'b0;
    #1;
    chk_idle("mid_rst");
    check_eq("mid_rst_wdata", 32'(bus.w_data), 0);
    @(negedge clk);
    bus.req_valid = 4'b1111;
    reset_n = 1'b1;
    #1; chk_idle("post_rst_bubble"); @(negedge clk);
    #1; chk_write("post_rst_first", 0); @(negedge clk);

`ifdef FIFO_WR_ARBITER_STATS_EN
    do_reset();
    #1;
    check_eq("stats_rst", 32'(acc_cnt[15:0]), 0);
    @(negedge clk);
    push_words(0, 6);
    push_words(1, 3);
    check_eq("stats_0", 32'(acc_cnt[15:0]), 6);
    check_eq("stats_1", 32'(acc_cnt[31:16]), 3);
    check_eq("stats_2", 32'(acc_cnt[47:32]), 0);
    check_eq("stats_3", 32'(acc_cnt[63:48]), 0);
`else
    do_reset();
    push_words(0, 6);
    push_words(1, 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one FIFO write port; legal range 2..8.
REQ-002 Parameter DATA_WIDTH, default 8: word width, matching the FIFO's DATA_WIDTH.
REQ-003 Parameter MAX_BURST, default 4: maximum words accepted per grant; legal range 1..16.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  NUM_REQ  per-requester word-valid.
REQ-008 req_data  input  NUM_REQ*DATA_WIDTH  flattened words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 req_ready  output  NUM_REQ  per-requester accept; a word transfers when valid and ready are both high at a clock edge.
REQ-010 full  input  1  FIFO full flag.
REQ-011 wr  output  1  FIFO write strobe.
REQ-012 w_data  output  DATA_WIDTH  FIFO write data.
REQ-013 grant_id  output  $clog2(NUM_REQ)  index of the current owner; 0 when idle.
REQ-014 busy  output  1  high while in GRANT.

Function
REQ-015 FSM states: IDLE and GRANT.
REQ-016 IDLE: if any req_valid bit is high, select the first valid requester scanning upward from rr_ptr, with wrap-around; register it as owner, clear burst_cnt, and go to GRANT on the next edge; otherwise stay in IDLE.
REQ-017 IDLE: all req_ready outputs and wr are low, giving one arbitration bubble cycle per grant.
REQ-018 GRANT: req_ready[owner] = ~full; all other req_ready bits are 0.
REQ-019 GRANT: wr = req_valid[owner] & ~full, combinationally; w_data = the owner's req_data slice.
REQ-020 GRANT: each accepted word increments burst_cnt.
REQ-021 GRANT exits to IDLE on the edge where either (a) a word is accepted with burst_cnt == MAX_BURST-1, or (b) req_valid[owner] is low.
REQ-022 On GRANT exit, rr_ptr is set to (owner+1) mod NUM_REQ.
REQ-023 full high during GRANT: the grant is held, wr and req_ready are low, burst_cnt is unchanged, and no timeout applies.
REQ-024 A requester dropping valid while full is high ends its grant per REQ-021(b).
REQ-025 Non-owner valid bits are ignored during GRANT and are never dropped; they wait for arbitration.
REQ-026 Only one requester valid: it is re-granted after each one-cycle bubble.
REQ-027 burst_cnt width is $clog2(MAX_BURST)+1 and never exceeds MAX_BURST-1.

Reset
REQ-028 Asserting reset_n low forces, asynchronously: state=IDLE, rr_ptr=0, owner=0, burst_cnt=0, wr=0, req_ready=0, grant_id=0, busy=0, w_data=0.
REQ-029 Reset asserted mid-burst abandons the burst; no partial-state recovery; first arbitration after release starts at requester 0.

Configuration
REQ-030 Macro FIFO_WR_ARBITER_STATS_EN.
REQ-031 When defined: add output acc_cnt, NUM_REQ*16 bits, holding per-requester accepted-word counters that saturate at 16'hFFFF and are cleared by reset.
REQ-032 When undefined: the port and its counters are absent, and all other behaviour is identical.

Structure
REQ-033 Shared package fifo_arb_pkg holds the FSM state typedef (IDLE, GRANT) and the stats counter width constant (16).
REQ-034 One sub-module, rr_pick: combinational round-robin first-one finder (inputs: valid vector, rr_ptr; outputs: index, found).

Verification
REQ-035 Reset, then req_valid=4'b0000 for 10 cycles -> wr=0, busy=0, grant_id=0 throughout.
REQ-036 req_valid=4'b1111 held continuously, full=0, MAX_BURST=4 -> grants in order 0,1,2,3,0; each grant gives 4 consecutive wr pulses followed by 1 idle cycle.
REQ-037 Owner 2 mid-burst after 2 words, full=1 for 5 cycles -> wr=0, req_ready=0, grant_id stays 2; after full drops, exactly 2 more words are accepted, then the grant releases.
REQ-038 Requester 1 sends 2 words then drops valid -> grant ends after 2 writes; next grant goes to requester 2 if valid, else wraps.
REQ-039 reset_n pulsed low during requester 3's burst -> all outputs 0 immediately; after release, requester 0 is granted first.
REQ-040 FIFO_WR_ARBITER_STATS_EN defined, 6 words from requester 0 and 3 words from requester 1 -> acc_cnt slice 0 = 6, slice 1 = 3, other slices 0.
